// File: rtl/icache_defs.sv
// Shared geometry, field layout and FSM encoding for the direct-mapped instruction cache.
package icache_defs;

    localparam int ADDR_W   = 10;
    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int BLOCK_W  = TAG_W + INDEX_W;
    localparam int LINES    = 1 << INDEX_W;
    localparam int WORD_W   = 32;
    localparam int LINE_W   = WORD_W << OFFSET_W;
    localparam int COUNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } cache_state_t;

    // Fetch address without its byte-select bits: {tag, index, word offset}.
    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } fetch_fields_t;

    function automatic logic [BLOCK_W-1:0] block_address(input fetch_fields_t f);
        return {f.tag, f.index};
    endfunction

endpackage

// File: rtl/icache_word_sel.sv
// Combinational 4:1 selection of one 32-bit instruction word out of a 128-bit cache line.
module icache_word_sel
    import icache_defs::*;
(
    input  logic [LINE_W-1:0]   line,
    input  logic [OFFSET_W-1:0] offset,
    output logic [WORD_W-1:0]   word
);

    always_comb begin
        word = line[WORD_W-1:0];
        case (offset)
            2'd0: word = line[WORD_W-1:0];
            2'd1: word = line[2*WORD_W-1:WORD_W];
            2'd2: word = line[3*WORD_W-1:2*WORD_W];
            2'd3: word = line[4*WORD_W-1:3*WORD_W];
            default: word = line[WORD_W-1:0];
        endcase
    end

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache: zero-latency hits, block refill on miss,
// saturating miss counter.
module icache_controller
    import icache_defs::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    output logic [WORD_W-1:0]   instruction,
    output logic                busywait,
    output logic [BLOCK_W-1:0]  mem_address,
    output logic                mem_read,
    input  logic [LINE_W-1:0]   mem_readdata,
    input  logic                mem_busywait,
    output logic [COUNT_W-1:0]  miss_count
);

    fetch_fields_t     fields;
    logic              unused_byte_bits;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags  [LINES];
    logic [LINE_W-1:0] lines [LINES];
    cache_state_t      state;
    logic              hit;
    logic              fill;
    logic [TAG_W-1:0]  fill_tag;
    logic [INDEX_W-1:0] fill_index;

    assign fields           = address[ADDR_W-1:2];
    assign unused_byte_bits = ^address[1:0];

    // The latched block address doubles as the refill target while in MEM_READ.
    assign {fill_tag, fill_index} = mem_address;

    assign hit      = read & valid[fields.index] & (tags[fields.index] == fields.tag);
    assign fill     = (state == MEM_READ) & ~mem_busywait;
    assign busywait = ~reset & ((state != IDLE) | (read & ~hit));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_address <= '0;
            miss_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read && !hit) begin
                        state       <= MEM_READ;
                        mem_read    <= 1'b1;
                        mem_address <= block_address(fields);
                        if (miss_count != '1) begin
                            miss_count <= miss_count + COUNT_W'(1);
                        end
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        state       <= UPDATE;
                        mem_read    <= 1'b0;
                        mem_address <= '0;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    mem_read    <= 1'b0;
                    mem_address <= '0;
                end
            endcase
        end
    end

    // Only the valid bits need clearing; stale tags and data are unreachable until refilled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (fill) begin
            valid[fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (fill) begin
            tags[fill_index]  <= fill_tag;
            lines[fill_index] <= mem_readdata;
        end
    end

    icache_word_sel u_word_sel (
        .line   (lines[fields.index]),
        .offset (fields.offset),
        .word   (instruction)
    );

endmodule

// File: tb/tb_icache_controller.sv
// Randomized self-checking bench: transaction-level cache model plus a memory responder.
module tb_icache_controller;

    logic         clock = 1'b0;
    logic         reset;
    logic [9:0]   address;
    logic         read;
    logic [31:0]  instruction;
    logic         busywait;
    logic [5:0]   mem_address;
    logic         mem_read;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b0;
    logic [15:0]  miss_count;

    int tests    = 0;
    int failures = 0;

    bit          chk_en = 1'b0;
    bit          exp_instr_chk = 1'b0;
    logic        exp_busywait = 1'b0;
    logic        exp_mem_read = 1'b0;
    logic [5:0]  exp_mem_address = '0;
    logic [15:0] exp_miss_count = '0;
    logic [31:0] exp_instr = '0;

    bit          m_valid [8];
    logic [2:0]  m_tag   [8];
    logic [15:0] m_misses = '0;
    int          mem_lat  = 0;
    int          mem_left = -1;

    icache_controller dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .read         (read),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .miss_count   (miss_count)
    );

    always #5 clock = ~clock;

    // Every memory word carries its own byte address, so any returned word identifies its source.
    function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] off);
        return {16'hC0DE, 6'd0, blk, off, 2'b00};
    endfunction

    function automatic logic [127:0] mem_block(input logic [5:0] blk);
        logic [127:0] b;
        for (int i = 0; i < 4; i++) begin
            b[i*32 +: 32] = mem_word(blk, 2'(i));
        end
        return b;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 3'd0;
        end
        m_misses = '0;
    endtask

    task automatic expect_cycle(input logic bw, input logic mr, input logic [5:0] ma,
                                input bit ichk, input logic [31:0] ins);
        exp_busywait    = bw;
        exp_mem_read    = mr;
        exp_mem_address = ma;
        exp_instr_chk   = ichk;
        exp_instr       = ins;
        exp_miss_count  = m_misses;
    endtask

    // Memory: holds mem_busywait high for mem_lat cycles of a request, then presents the block.
    always @(posedge clock) begin
        #2;
        if (mem_read !== 1'b1) begin
            mem_busywait = 1'b0;
            mem_left     = -1;
        end else begin
            if (mem_left < 0) mem_left = mem_lat;
            if (mem_left > 0) begin
                mem_busywait = 1'b1;
                mem_left--;
                mem_readdata = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                mem_busywait = 1'b0;
                mem_readdata = mem_block(mem_address);
            end
        end
    end

    // Single compare process: every cycle the bench has armed, outputs must match the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check_output("busywait", 32'(busywait), 32'(exp_busywait));
            check_output("mem_read", 32'(mem_read), 32'(exp_mem_read));
            check_output("mem_address", 32'(mem_address), 32'(exp_mem_address));
            check_output("miss_count", 32'(miss_count), 32'(exp_miss_count));
            if (exp_instr_chk) check_output("instruction", instruction, exp_instr);
        end
    end

    task automatic idle_cycle();
        @(posedge clock);
        #1;
        read    = 1'b0;
        address = 10'($urandom);
        expect_cycle(1'b0, 1'b0, 6'd0, 1'b0, 32'd0);
        @(negedge clock);
    endtask

    // One CPU fetch held until the stall clears; a miss costs lat+3 stalled cycles.
    task automatic apply_stimulus(input logic [9:0] addr, input int lat, input bit scramble);
        logic [5:0] blk;
        logic [2:0] idx;
        logic [2:0] tg;
        logic [1:0] off;
        bit         hit;
        blk = addr[9:4];
        idx = addr[6:4];
        tg  = addr[9:7];
        off = addr[3:2];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        @(posedge clock);
        #1;
        address = addr;
        read    = 1'b1;
        mem_lat = lat;
        if (hit) begin
            expect_cycle(1'b0, 1'b0, 6'd0, 1'b1, mem_word(blk, off));
            @(negedge clock);
        end else begin
            expect_cycle(1'b1, 1'b0, 6'd0, 1'b0, 32'd0);
            @(negedge clock);
            for (int k = 1; k <= lat + 3; k++) begin
                @(posedge clock);
                #1;
                if (k == 1 && m_misses != 16'hFFFF) m_misses++;
                address = (scramble && k <= lat + 2) ? 10'($urandom) : addr;
                expect_cycle(k <= lat + 2, k <= lat + 1, (k <= lat + 1) ? blk : 6'd0,
                             k == lat + 3, mem_word(blk, off));
                @(negedge clock);
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(posedge clock);
        #1;
        read  = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        clear_model();
        expect_cycle(1'b0, 1'b0, 6'd0, 1'b0, 32'd0);
        chk_en = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #4_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clear_model();
        reset   = 1'b1;
        read    = 1'b1;
        address = 10'h004;
        #12;
        check_output("reset busywait", 32'(busywait), 32'd0);
        check_output("reset mem_read", 32'(mem_read), 32'd0);
        check_output("reset mem_address", 32'(mem_address), 32'd0);
        check_output("reset miss_count", 32'(miss_count), 32'd0);
        read = 1'b0;
        #1;
        reset = 1'b0;
        expect_cycle(1'b0, 1'b0, 6'd0, 1'b0, 32'd0);
        chk_en = 1'b1;

        // Cold miss with five busy memory cycles, then the retried fetch hits.
        apply_stimulus(10'h004, 5, 1'b1);
        check_output("fill word1", instruction, 32'hC0DE0004);
        check_output("fill busywait", 32'(busywait), 32'd0);

        apply_stimulus(10'h000, 0, 1'b0);
        check_output("hit word0", instruction, 32'hC0DE0000);
        apply_stimulus(10'h008, 0, 1'b0);
        apply_stimulus(10'h00C, 0, 1'b0);
        check_output("hit word3", instruction, 32'hC0DE000C);
        check_output("hits keep miss_count", 32'(miss_count), 32'd1);

        // Conflict on index 0 evicts tag 0, so the original address misses again.
        apply_stimulus(10'h084, 2, 1'b1);
        check_output("conflict word1", instruction, 32'hC0DE0084);
        apply_stimulus(10'h004, 0, 1'b0);
        check_output("refetch miss_count", 32'(miss_count), 32'd3);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            apply_stimulus({3'($urandom_range(0, 1)), 7'($urandom)}, $urandom_range(0, 4),
                           1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a refill aborts it; the same address must miss afterwards.
        do_reset();
        chk_en = 1'b0;
        @(posedge clock);
        #1;
        address = 10'h3A8;
        read    = 1'b1;
        mem_lat = 6;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check_output("pre-abort mem_read", 32'(mem_read), 32'd1);
        reset = 1'b1;
        #1;
        check_output("abort mem_read", 32'(mem_read), 32'd0);
        check_output("abort mem_address", 32'(mem_address), 32'd0);
        check_output("abort busywait", 32'(busywait), 32'd0);
        check_output("abort miss_count", 32'(miss_count), 32'd0);
        read = 1'b0;
        #1;
        reset = 1'b0;
        clear_model();
        expect_cycle(1'b0, 1'b0, 6'd0, 1'b0, 32'd0);
        chk_en = 1'b1;
        apply_stimulus(10'h3A8, 1, 1'b0);
        check_output("post-abort miss_count", 32'(miss_count), 32'd1);
        check_output("post-abort word", instruction, 32'hC0DE03A8);

        // Alternating tags on one index force a miss on every fetch until the counter saturates.
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            apply_stimulus((i % 2 == 1) ? 10'h080 : 10'h000, 0, 1'b0);
        end
        check_output("saturated miss_count", 32'(miss_count), 32'h0000FFFF);
        apply_stimulus(10'h080, 0, 1'b0);
        check_output("held miss_count", 32'(miss_count), 32'h0000FFFF);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
